// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the core accumulator CPU and its program loader:
// default data/address widths, program RAM depth and the loader controller
// state encoding.
// -----------------------------------------------------------------------------
package core_pkg;

  localparam int CORE_WORD_WIDTH = 8;
  localparam int CORE_ADDR_WIDTH = $clog2(CORE_WORD_WIDTH);
  localparam int CORE_RAM_DEPTH  = 2 ** CORE_ADDR_WIDTH;

  typedef enum logic [1:0] {
    RUN,      // core owns the RAM write port
    DRAIN,    // core stalled, one cycle for its last write to land
    LOAD,     // loader stream owns the RAM write port
    RELEASE   // core held in synchronous reset before restarting at PC=0
  } ctrl_state_t;

endpackage

// File: rtl/reset_pulse_gen.sv
// -----------------------------------------------------------------------------
// reset_pulse_gen
// Load/count-down counter producing a registered active-high reset pulse of
// exactly reset_cycles cycles. The pulse is high out of controller reset, so
// the core always restarts after a controller reset.
//
// Ports:
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset
//   i_load   in   (re)start a pulse; high from the next edge
//   o_pulse  out  registered reset pulse
//   o_done   out  pulse is in its final cycle (drops at the next edge)
// -----------------------------------------------------------------------------
module reset_pulse_gen #(
  parameter int reset_cycles = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_load,
  output logic o_pulse,
  output logic o_done
);

  localparam int            CW       = (reset_cycles > 1) ? $clog2(reset_cycles) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(reset_cycles - 1);

  logic [CW-1:0] r_cnt;
  logic          r_pulse;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= LOAD_VAL;
      r_pulse <= 1'b1;
    end else if (i_load) begin
      r_cnt   <= LOAD_VAL;
      r_pulse <= 1'b1;
    end else if (r_pulse) begin
      if (r_cnt == '0) r_pulse <= 1'b0;
      else             r_cnt   <= r_cnt - CW'(1);
    end
  end

  assign o_pulse = r_pulse;
  assign o_done  = r_pulse && (r_cnt == '0);

endmodule

// File: rtl/core_loader_ctrl.sv
// -----------------------------------------------------------------------------
// core_loader_ctrl
// Owns the program RAM write port. In RUN the core's writes pass straight
// through; on a load request the core is stalled, the loader stream is
// written from address 0, and the core is restarted with a reset pulse.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   ld_start                     single-cycle load request (honoured in RUN)
//   ld_valid/ld_ready/ld_data    loader word handshake
//   ld_last                      final word of the image
//   core_write/waddr/wdata       core write request
//   core_clk_en, core_reset      core clock enable, synchronous core reset
//   mem_we/mem_waddr/mem_wdata   RAM write port (combinational mux)
//   busy                         high in every state except RUN
//   loaded_count                 words written by the most recent load
//   err_overflow                 sticky: image ran past the last RAM address
// -----------------------------------------------------------------------------
module core_loader_ctrl
  import core_pkg::*;
#(
  parameter int word_width   = CORE_WORD_WIDTH,
  parameter int addr_width   = $clog2(word_width),
  parameter int reset_cycles = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [word_width-1:0] ld_data,
  input  logic                  ld_last,
  input  logic                  core_write,
  input  logic [addr_width-1:0] core_waddr,
  input  logic [word_width-1:0] core_wdata,
  output logic                  core_clk_en,
  output logic                  core_reset,
  output logic                  mem_we,
  output logic [addr_width-1:0] mem_waddr,
  output logic [word_width-1:0] mem_wdata,
  output logic                  busy,
  output logic [addr_width:0]   loaded_count,
  output logic                  err_overflow
);

  ctrl_state_t           r_state;
  logic                  r_clk_en;
  logic                  r_ld_ready;
  logic                  r_busy;
  logic [addr_width:0]   r_loaded_count;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_at_top;
  logic                  w_load_end;
  logic                  w_rst_pulse;
  logic                  w_rst_done;

  assign w_accept   = (r_state == LOAD) && ld_valid && r_ld_ready;
  // The word about to be written lands in the last RAM location.
  assign w_at_top   = (r_loaded_count[addr_width-1:0] == '1);
  assign w_load_end = w_accept && (ld_last || w_at_top);

  reset_pulse_gen #(
    .reset_cycles (reset_cycles)
  ) u_reset_pulse (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_load_end),
    .o_pulse (w_rst_pulse),
    .o_done  (w_rst_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= RELEASE;
      r_clk_en       <= 1'b0;
      r_ld_ready     <= 1'b0;
      r_busy         <= 1'b1;
      r_loaded_count <= '0;
      r_err          <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (ld_start) begin
            r_state  <= DRAIN;
            r_clk_en <= 1'b0;
            r_busy   <= 1'b1;
            r_err    <= 1'b0;
          end
        end
        DRAIN: begin
          r_state        <= LOAD;
          r_ld_ready     <= 1'b1;
          r_loaded_count <= '0;
        end
        LOAD: begin
          if (w_accept) begin
            r_loaded_count <= r_loaded_count + (addr_width + 1)'(1);
            if (w_load_end) begin
              r_state    <= RELEASE;
              r_ld_ready <= 1'b0;
              r_clk_en   <= 1'b1;
              if (!ld_last) r_err <= 1'b1;
            end
          end
        end
        RELEASE: begin
          // Core is clocked while held in reset so the reset takes effect.
          r_clk_en <= 1'b1;
          if (w_rst_done) begin
            r_state <= RUN;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= RELEASE;
      endcase
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = core_waddr;
    mem_wdata = core_wdata;
    case (r_state)
      RUN:  mem_we = core_write;
      LOAD: begin
        mem_we    = w_accept;
        mem_waddr = r_loaded_count[addr_width-1:0];
        mem_wdata = ld_data;
      end
      default: mem_we = 1'b0;
    endcase
  end

  assign ld_ready     = r_ld_ready;
  assign core_clk_en  = r_clk_en;
  assign core_reset   = w_rst_pulse;
  assign busy         = r_busy;
  assign loaded_count = r_loaded_count;
  assign err_overflow = r_err;

endmodule

// File: tb/tb_core_loader_ctrl.sv
// -----------------------------------------------------------------------------
// tb_core_loader_ctrl
// Directed bench for core_loader_ctrl with a behavioural program RAM on the
// write port. Inputs change on the falling edge; outputs are sampled there
// (registered) or 1 time unit after an input change (combinational).
// -----------------------------------------------------------------------------
module tb_core_loader_ctrl;
  import core_pkg::*;

  localparam int WW = 8;
  localparam int AW = 3;

  logic          clk;
  logic          reset_n;
  logic          ld_start;
  logic          ld_valid;
  logic          ld_ready;
  logic [WW-1:0] ld_data;
  logic          ld_last;
  logic          core_write;
  logic [AW-1:0] core_waddr;
  logic [WW-1:0] core_wdata;
  logic          core_clk_en;
  logic          core_reset;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [WW-1:0] mem_wdata;
  logic          busy;
  logic [AW:0]   loaded_count;
  logic          err_overflow;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int wr_base  = 0;

  logic [WW-1:0] ram [CORE_RAM_DEPTH];

  core_loader_ctrl #(
    .word_width   (WW),
    .addr_width   (AW),
    .reset_cycles (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ld_start     (ld_start),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .core_write   (core_write),
    .core_waddr   (core_waddr),
    .core_wdata   (core_wdata),
    .core_clk_en  (core_clk_en),
    .core_reset   (core_reset),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .loaded_count (loaded_count),
    .err_overflow (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_waddr] <= mem_wdata;
      wr_cnt         <= wr_cnt + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_clk_en"},  32'(core_clk_en),  0);
    check({tag, "_core_rst"}, 32'(core_reset),  1);
    check({tag, "_ld_ready"}, 32'(ld_ready),    0);
    check({tag, "_busy"},     32'(busy),        1);
    check({tag, "_count"},    32'(loaded_count), 0);
    check({tag, "_err"},      32'(err_overflow), 0);
  endtask

  // ld_start pulse at a falling edge; returns in the first LOAD cycle.
  task automatic start_load();
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset_n    = 1'b0;
    ld_start   = 1'b0;
    ld_valid   = 1'b0;
    ld_data    = '0;
    ld_last    = 1'b0;
    core_write = 1'b0;
    core_waddr = '0;
    core_wdata = '0;

    // ---- power-on reset and release sequence ----
    repeat (2) @(negedge clk);
    check_reset_values("por");
    reset_n = 1'b1;
    @(negedge clk);
    check("rel1_core_reset", 32'(core_reset),  1);
    check("rel1_clk_en",     32'(core_clk_en), 1);
    check("rel1_busy",       32'(busy),        1);
    @(negedge clk);
    check("run_core_reset",  32'(core_reset),  0);
    check("run_busy",        32'(busy),        0);
    check("run_clk_en",      32'(core_clk_en), 1);

    // ---- passthrough in RUN ----
    core_write = 1'b1; core_waddr = 3'd5; core_wdata = 8'h3C;
    #1;
    check("pass_we",    32'(mem_we),    1);
    check("pass_waddr", 32'(mem_waddr), 5);
    check("pass_wdata", 32'(mem_wdata), 32'h3C);
    @(negedge clk);
    core_write = 1'b0;
    check("pass_ram5",  32'(ram[5]),    32'h3C);

    // ---- load of three words; core write during DRAIN is blocked ----
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    check("drain_busy",     32'(busy),        1);
    check("drain_clk_en",   32'(core_clk_en), 0);
    check("drain_ld_ready", 32'(ld_ready),    0);
    core_write = 1'b1; core_waddr = 3'd2; core_wdata = 8'hFF;
    #1;
    check("drain_core_we",  32'(mem_we),      0);
    @(negedge clk);
    core_write = 1'b0;
    check("load_ld_ready",  32'(ld_ready),    1);
    check("load_count0",    32'(loaded_count), 0);
    check("load_clk_en",    32'(core_clk_en), 0);
    ld_valid = 1'b1; ld_data = 8'h21; ld_start = 1'b1;
    #1;
    check("load_w0_we",     32'(mem_we),    1);
    check("load_w0_addr",   32'(mem_waddr), 0);
    check("load_w0_data",   32'(mem_wdata), 32'h21);
    @(negedge clk);
    ld_start = 1'b0;
    check("load_ign_start_ready", 32'(ld_ready),     1);
    check("load_ign_start_count", 32'(loaded_count), 1);
    check("load_clk_en_mid",      32'(core_clk_en),  0);
    ld_data = 8'h05;
    #1;
    check("load_w1_addr",   32'(mem_waddr), 1);
    @(negedge clk);
    ld_data = 8'h40; ld_last = 1'b1;
    #1;
    check("load_w2_addr",   32'(mem_waddr), 2);
    @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0;
    check("rel_core_reset", 32'(core_reset),   1);
    check("rel_clk_en",     32'(core_clk_en),  1);
    check("rel_ld_ready",   32'(ld_ready),     0);
    check("load_count3",    32'(loaded_count), 3);
    check("load_err",       32'(err_overflow), 0);
    check("load_ram0",      32'(ram[0]), 32'h21);
    check("load_ram1",      32'(ram[1]), 32'h05);
    check("load_ram2",      32'(ram[2]), 32'h40);
    @(negedge clk);
    check("rel2_core_reset", 32'(core_reset), 1);
    @(negedge clk);
    check("rerun_core_reset", 32'(core_reset), 0);
    check("rerun_busy",       32'(busy),       0);

    // ---- backpressure: valid pattern 1,0,0,1 ----
    start_load();
    wr_base = wr_cnt;
    ld_valid = 1'b1; ld_data = 8'hA1;
    #1;
    check("bp_w0_we",   32'(mem_we),    1);
    check("bp_w0_addr", 32'(mem_waddr), 0);
    @(negedge clk);
    ld_valid = 1'b0; ld_data = 8'hEE;
    #1;
    check("bp_gap1_we", 32'(mem_we), 0);
    @(negedge clk);
    #1;
    check("bp_gap2_we", 32'(mem_we), 0);
    check("bp_gap_count", 32'(loaded_count), 1);
    @(negedge clk);
    ld_valid = 1'b1; ld_data = 8'hA2; ld_last = 1'b1;
    #1;
    check("bp_w1_addr", 32'(mem_waddr), 1);
    @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0;
    check("bp_writes",  32'(wr_cnt - wr_base), 2);
    check("bp_count",   32'(loaded_count), 2);
    check("bp_ram0",    32'(ram[0]), 32'hA1);
    check("bp_ram1",    32'(ram[1]), 32'hA2);
    check("bp_ram2",    32'(ram[2]), 32'h40);
    repeat (2) @(negedge clk);
    check("bp_run_busy", 32'(busy), 0);

    // ---- overflow: eight words without ld_last ----
    start_load();
    wr_base = wr_cnt;
    for (int i = 0; i < 8; i++) begin
      ld_valid = 1'b1; ld_data = 8'(16 + i);
      #1;
      check("ovf_addr", 32'(mem_waddr), 32'(i));
      @(negedge clk);
    end
    ld_data = 8'h99;
    #1;
    check("ovf_9th_ready", 32'(ld_ready),     0);
    check("ovf_9th_we",    32'(mem_we),       0);
    check("ovf_err",       32'(err_overflow), 1);
    check("ovf_count",     32'(loaded_count), 8);
    @(negedge clk);
    ld_valid = 1'b0;
    check("ovf_writes", 32'(wr_cnt - wr_base), 8);
    for (int i = 0; i < 8; i++) begin
      check("ovf_ram", 32'(ram[i]), 32'(16 + i));
    end
    @(negedge clk);
    check("ovf_run_busy",   32'(busy),         0);
    check("ovf_err_sticky", 32'(err_overflow), 1);

    // ---- entry to DRAIN clears the overflow flag ----
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    check("drain_err_clr", 32'(err_overflow), 0);
    @(negedge clk);
    ld_valid = 1'b1; ld_data = 8'h77;
    @(negedge clk);
    ld_valid = 1'b0;
    check("abort_count1", 32'(loaded_count), 1);

    // ---- asynchronous reset mid-cycle, mid-load ----
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("async");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("arel1_core_reset", 32'(core_reset),  1);
    check("arel1_clk_en",     32'(core_clk_en), 1);
    @(negedge clk);
    check("arun_core_reset",  32'(core_reset),  0);
    check("arun_busy",        32'(busy),        0);
    check("arun_clk_en",      32'(core_clk_en), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_loader_ctrl.md
# core_loader_ctrl

Controller that owns the program RAM write port and sequences the `core` accumulator CPU around a program load. In normal operation it forwards the core's write requests to the RAM. On a load request it stalls the core, streams words from the UART receive side into RAM from address 0, then restarts the core with a synchronous reset pulse. It sits between the UART byte receiver, the shared RAM and the core's clock-enable/reset inputs.

## Interface
- `word_width`, 8: RAM/core data width.
- `addr_width`, `$clog2(word_width)`: RAM address width; depth = 2**addr_width.
- `reset_cycles`, 2: length of the `core_reset` pulse, in cycles, ≥1.
- `clk`  in  1  single clock for controller, RAM write port and core.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ld_start`  in  1  single-cycle load request.
- `ld_valid`  in  1  loader word valid.
- `ld_ready`  out  1  loader word accepted when `ld_valid & ld_ready`.
- `ld_data`  in  word_width  loader word.
- `ld_last`  in  1  marks final word of the image.
- `core_write`  in  1  core write request.
- `core_waddr`  in  addr_width  core write address (`operand_addr`).
- `core_wdata`  in  word_width  core write data (accumulator).
- `core_clk_en`  out  1  enable for the core's gated clock.
- `core_reset`  out  1  active-high synchronous reset to the core.
- `mem_we`  out  1  RAM write strobe.
- `mem_waddr`  out  addr_width  RAM write address.
- `mem_wdata`  out  word_width  RAM write data.
- `busy`  out  1  high in every state except RUN.
- `loaded_count`  out  addr_width+1  words written by the most recent load.
- `err_overflow`  out  1  sticky; image exceeded RAM depth.

## Operation
- States: RUN, DRAIN, LOAD, RELEASE. State after `reset_n` deasserts: RELEASE, so the core is always reset after a controller reset.
- RUN: `core_clk_en`=1, `core_reset`=0, `ld_ready`=0. RAM port is muxed from the core: `mem_we`=`core_write`, `mem_waddr`=`core_waddr`, `mem_wdata`=`core_wdata`. `ld_start` moves to DRAIN. `ld_valid` is ignored.
- DRAIN: `core_clk_en`=0, `mem_we`=0. Lasts exactly one cycle, then LOAD. `loaded_count` clears to 0 on entry to LOAD.
- LOAD: `core_clk_en`=0, `ld_ready`=1. `mem_we`=`ld_valid`, `mem_waddr`=`loaded_count[addr_width-1:0]`, `mem_wdata`=`ld_data`. Each accepted word increments `loaded_count`.
- Leaving LOAD: an accepted word with `ld_last`=1 goes to RELEASE. The word written at address depth-1 with `ld_last`=0 also goes to RELEASE and sets `err_overflow`. No further words are accepted after that.
- RELEASE: `core_clk_en`=1, `core_reset`=1 for `reset_cycles` cycles, using an internal down-counter. Then RUN with PC=0 in the core.
- `ld_start` outside RUN is ignored. `err_overflow` clears only on `reset_n` or on entry to DRAIN.
- `reset_n` asserted mid-load aborts immediately. RAM contents are undefined; the next state is RELEASE.

## Timing
- Async reset values: `core_clk_en`=0, `core_reset`=1, `ld_ready`=0, `busy`=1, `loaded_count`=0, `err_overflow`=0, state=RELEASE, counter=`reset_cycles`-1.
- `mem_we`/`mem_waddr`/`mem_wdata` are combinational from state and the active source. All other outputs are registered.
- `ld_start` high at edge t: DRAIN from t+1. `core_clk_en` is low from t+1, so a core write present in cycle t completes. `ld_ready` rises at t+2.
- Load throughput is one word per cycle. The final word accepted at edge e puts `core_reset` high from e for `reset_cycles` cycles. RUN starts at e+`reset_cycles`.
- The core never sees a clock edge with `core_reset`=0 between DRAIN and the end of RELEASE.

## Structure
- Shared package `core_pkg`: `ctrl_state_t` enum (RUN, DRAIN, LOAD, RELEASE) and the localparam for RAM depth.
- One sub-module, `reset_pulse_gen`: a load/count-down counter driving `core_reset`. The FSM, source mux and counters stay in `core_loader_ctrl`.

## Test plan
- Reset: drop `reset_n` asynchronously mid-cycle. Required: outputs take reset values immediately. After release, `core_reset` stays high exactly 2 cycles, then `core_clk_en`=1 and `busy`=0.
- Passthrough: in RUN, `core_write`=1, `core_waddr`=5, `core_wdata`=0x3C. Required: same cycle, `mem_we`=1, `mem_waddr`=5, `mem_wdata`=0x3C.
- Load: `ld_start`, then 3 words 0x21,0x05,0x40 with `ld_last` on the third. Required: RAM[0..2] hold them, `loaded_count`=3, `err_overflow`=0. `core_clk_en`=0 from DRAIN through LOAD.
- Backpressure gaps: `ld_valid` toggles 1,0,0,1. Required: only 2 writes, to addresses 0 and 1. Idle cycles leave `mem_we`=0.
- Overflow: 8 words, none with `ld_last`. Required: RAM[0..7] written, `loaded_count`=8, `err_overflow`=1. A 9th word sees `ld_ready`=0.
- Ignored events: `ld_start` during LOAD and `core_write`=1 during DRAIN. Required: no state change and `mem_we`=0 from the core.
